// File: rtl/count4_checker.sv
// Sequence checker for a free-running 4-bit up-counter: acquires lock after LOCK_N correct increments.
// Optional macro COUNT4_CHECKER_ERRCNT_EN builds the saturating err_cnt counter and its clr_err clear.
module count4_checker #(
    parameter int LOCK_N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] val_in,
    input  logic       val_valid,
    input  logic       clr_err,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N4 = LOCK_N[3:0];

    state_t     state_q, state_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] run_q, run_d;
    logic [3:0] run_inc;
    logic       locked_q, locked_d;
    logic       err_q, err_d;
    logic       match;
    logic       err_event;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // 4-bit compare wraps naturally, so 15 followed by 0 is a match
    assign match   = (val_in == prev_q + 4'd1);
    assign run_inc = run_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        run_d     = run_q;
        err_event = 1'b0;
        if (val_valid) begin
            prev_d = val_in;
            case (state_q)
                IDLE: begin
                    run_d   = 4'd0;
                    state_d = ACQ;
                end
                ACQ: begin
                    if (match) begin
                        run_d = run_inc;
                        if (run_inc == LOCK_N4) begin
                            state_d = LOCK;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                LOCK: begin
                    if (!match) begin
                        err_event = 1'b1;
                        run_d     = 4'd0;
                        state_d   = ACQ;
                    end
                end
                default: begin
                    run_d   = 4'd0;
                    state_d = IDLE;
                end
            endcase
        end
        locked_d = (state_d == LOCK);
        err_d    = err_event;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            prev_q   <= 4'd0;
            run_q    <= 4'd0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            run_q    <= run_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign locked = locked_q;
    assign err    = err_q;

`ifdef COUNT4_CHECKER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Clear wins over the old value but still counts an error on the same edge
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = err_event ? 8'd1 : 8'd0;
        end else if (err_event) begin
            err_cnt_d = sat_inc8(err_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_errcnt_inputs;
    logic [7:0] unused_sat;
    assign unused_sat           = sat_inc8(8'd0);
    assign unused_errcnt_inputs = clr_err ^ (|unused_sat);
    assign err_cnt              = 8'd0;
`endif

endmodule

// File: tb/tb_count4_checker.sv
// Randomized self-checking bench for count4_checker against a sample-history reference model.
module tb_count4_checker;

    localparam int LOCK_N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] val_in = 4'd0;
    logic       val_valid = 1'b0;
    logic       clr_err = 1'b0;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    count4_checker #(.LOCK_N(LOCK_N)) dut (
        .clk      (clk),
        .rst      (rst),
        .val_in   (val_in),
        .val_valid(val_valid),
        .clr_err  (clr_err),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the valid samples since reset, plus lock / error bookkeeping
    int m_hist[$];
    bit m_locked;
    bit m_err;
    int m_errcnt;
    int m_streak_at_lock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int trailing_matches();
        int n = 0;
        for (int i = m_hist.size() - 1; i > 0; i--) begin
            if (m_hist[i] == (m_hist[i-1] + 1) % 16) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_locked = 0;
        m_err = 0;
        m_errcnt = 0;
        m_streak_at_lock = 0;
    endtask

    task automatic model_update(input bit v, input int d, input bit c);
        m_err = 0;
        if (v) begin
            m_hist.push_back(d);
            if (m_hist.size() > 1) begin
                if (d == (m_hist[m_hist.size()-2] + 1) % 16) begin
                    // Streak counts only matches after the last break (or the first sample)
                    if (!m_locked && trailing_matches() - m_streak_at_lock >= LOCK_N) m_locked = 1;
                end else begin
                    if (m_locked) begin
                        m_err = 1;
                        m_locked = 0;
                        if (m_errcnt < 255) m_errcnt++;
                    end
                    m_streak_at_lock = 0;
                end
            end
            if (m_hist.size() > 64) begin
                m_hist.delete(0);
            end
        end
`ifdef COUNT4_CHECKER_ERRCNT_EN
        if (c) m_errcnt = m_err ? 1 : 0;
`else
        m_errcnt = 0;
`endif
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".locked"}, int'(locked), int'(m_locked));
        check({tag, ".err"}, int'(err), int'(m_err));
        check({tag, ".err_cnt"}, int'(err_cnt), m_errcnt);
    endtask

    task automatic step(input bit v, input int d, input bit c);
        @(negedge clk);
        val_valid = v;
        val_in    = d[3:0];
        clr_err   = c;
        @(posedge clk);
        #1;
        model_update(v, d, c);
        compare_all("step");
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all("rst_async");
        val_valid = 1'b1;
        val_in    = 4'($urandom);
        clr_err   = 1'b1;
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        val_valid = 1'b0;
        clr_err = 1'b0;
    endtask

    // First sample plus LOCK_N increments; returns the last value presented
    task automatic lock_from(input int start, output int last);
        step(1, start % 16, 0);
        for (int i = 1; i <= LOCK_N; i++) step(1, (start + i) % 16, 0);
        last = (start + LOCK_N) % 16;
    endtask

    initial begin
        int last;
        int v;
        model_reset();
        #3;
        compare_all("reset");
        async_reset();

        // Lock on 0..4, wrap through 15->0, break 5->7, relock, idle gap
        for (int i = 0; i <= 4; i++) step(1, i, 0);
        check("lock_after_4", int'(locked), 1);
        step(1, 5, 0);
        step(1, 7, 0);
        check("break_err", int'(err), 1);
        check("break_unlock", int'(locked), 0);
        for (int i = 8; i <= 11; i++) step(1, i, 0);
        check("relock_11", int'(locked), 1);
        for (int i = 12; i <= 17; i++) step(1, i % 16, 0);
        check("wrap_locked", int'(locked), 1);
        step(1, 2, 0);
        for (int i = 0; i < 3; i++) step(0, 9, 0);
        step(1, 3, 0);
        check("idle_no_err", int'(err), 0);
        check("idle_locked", int'(locked), 1);

        // Three breaks then async reset while locked
        async_reset();
        for (int k = 0; k < 3; k++) begin
            lock_from(k * 5, last);
            step(1, (last + 2) % 16, 0);
        end
        lock_from(3, last);
        check("pre_rst_locked", int'(locked), 1);
        async_reset();
        check("post_rst_errcnt", int'(err_cnt), 0);

        // Drive err_cnt into saturation, then clear on the same edge as a break
        for (int k = 0; k < 257; k++) begin
            lock_from(k % 16, last);
            step(1, (last + 2) % 16, 0);
        end
        check("sat_err_pulse", int'(err), 1);
        lock_from(6, last);
        step(1, (last + 5) % 16, 1);
        check("clr_with_break_err", int'(err), 1);

        // Random phase: mostly incrementing stream with jumps, gaps, clears and resets
        async_reset();
        v = 0;
        for (int i = 0; i < 3000; i++) begin
            bit vv;
            bit cc;
            if ($urandom_range(0, 399) == 0) async_reset();
            vv = ($urandom_range(0, 9) < 8);
            cc = ($urandom_range(0, 29) == 0);
            if (vv) v = ($urandom_range(0, 19) < 18) ? (v + 1) % 16 : $urandom_range(0, 15);
            step(vv, vv ? v : $urandom_range(0, 15), cc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/count4_checker.md
COUNT4_CHECKER -- requirements
Module: count4_checker

Interface
REQ-001 SHALL have parameter LOCK_N, default 4: consecutive correct increments needed to declare lock; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port val_in  input  4  sampled count value from the monitored 4-bit up-counter.
REQ-005 SHALL have port val_valid  input  1  val_in is sampled on this edge only when 1.
REQ-006 SHALL have port clr_err  input  1  synchronous clear of err_cnt.
REQ-007 SHALL have port locked  output  1  high while the stream is verified to be incrementing.
REQ-008 SHALL have port err  output  1  one-cycle pulse on a sequence break while locked.
REQ-009 SHALL have port err_cnt  output  8  saturating count of sequence breaks.

Function
REQ-010 SHALL treat edges with val_valid=0 as idle: state, stored previous value, run count and outputs hold, except that err SHALL return to 0.
REQ-011 SHALL define a match as val_in == (prev + 1) mod 16; 15 followed by 0 is a match.
REQ-012 SHALL implement states IDLE, ACQ and LOCK, encoded internally.
REQ-013 IDLE: on a valid sample, SHALL store prev=val_in, clear run=0 and go to ACQ.
REQ-014 ACQ: on a valid match, SHALL increment run; when the incremented run equals LOCK_N, SHALL go to LOCK.
REQ-015 ACQ: on a valid mismatch, SHALL clear run=0, stay in ACQ and not assert err.
REQ-016 LOCK: on a valid match, SHALL stay in LOCK.
REQ-017 LOCK: on a valid mismatch, SHALL assert err for exactly one cycle, increment err_cnt, clear run=0 and go to ACQ.
REQ-018 SHALL update prev=val_in on every valid sample in every state.
REQ-019 SHALL register all outputs; locked equals (state==LOCK); err and err_cnt change at the same edge that samples the offending value.
REQ-020 SHALL saturate err_cnt at 255 with no wrap.
REQ-021 clr_err=1 SHALL set err_cnt=0; when asserted on the same edge as an error increment, err_cnt SHALL become 1.
REQ-022 SHALL use modulo-16 arithmetic for the prev+1 comparison and 4-bit width for run.

Reset
REQ-023 rst=1 SHALL immediately, without a clock edge, force state=IDLE, prev=0, run=0, locked=0, err=0, err_cnt=0.
REQ-024 Reset asserted mid-operation, in any state, SHALL discard lock; after release the first valid sample is handled as in IDLE.
REQ-025 SHALL hold all outputs at their reset values while rst=1, regardless of val_valid or clr_err.

Configuration
REQ-026 Macro COUNT4_CHECKER_ERRCNT_EN defined: the err_cnt counter and clr_err logic SHALL be built per REQ-020 and REQ-021.
REQ-027 Macro COUNT4_CHECKER_ERRCNT_EN undefined: err_cnt SHALL be constant 0, clr_err SHALL be ignored, and err, locked and the state machine SHALL behave identically to the defined case.

Verification
REQ-028 Reset, LOCK_N=4, valid samples 0,1,2,3,4 on consecutive edges -> locked=1 after the 5th sample edge; err=0 throughout.
REQ-029 Locked, samples 14,15,0,1 -> locked stays 1; err=0; err_cnt unchanged.
REQ-030 Locked, last sample 5, next sample 7 -> err=1 for one cycle, err_cnt=1, locked=0; then 8,9,10,11 -> locked=1 after 11.
REQ-031 Locked, last sample 2, val_valid=0 for 3 cycles with val_in=9, then valid sample 3 -> no err; locked stays 1.
REQ-032 err_cnt=255 plus another break -> err_cnt stays 255 and err pulses; then clr_err=1 on the same edge as a break -> err_cnt=1.
REQ-033 While locked with err_cnt=3, assert rst between clock edges -> locked=0 and err_cnt=0 immediately; build without the macro -> err_cnt=0 in all scenarios.
